// File: rtl/bank_write_streamer.sv
// Packs a serial stream of qubit ROI sums into 4-wide rows and writes one row per 4 accepts.
// Optional macro WRITE_STREAM_ID_CHECK_EN enables the sticky qubit-ID sequence check.
module bank_write_streamer #(
   parameter int ROI_BITS        = 16,
   parameter int NUM_BANKS       = 4,
   parameter int ROWS_PER_BANK   = 25,
   parameter int BANK_ADDR_WIDTH = 5,
   parameter int QUBIT_ID_WIDTH  = 7
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic                       i_px_valid,
   input  logic [ROI_BITS-1:0]        i_px_data,
   input  logic [QUBIT_ID_WIDTH-1:0]  i_px_qubit_id,
   output logic                       o_px_ready,
   output logic                       o_wr_en,
   output logic [BANK_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [ROI_BITS-1:0]        o_wr_data_0,
   output logic [ROI_BITS-1:0]        o_wr_data_1,
   output logic [ROI_BITS-1:0]        o_wr_data_2,
   output logic [ROI_BITS-1:0]        o_wr_data_3,
   output logic                       o_busy,
   output logic                       o_frame_done,
   output logic                       o_id_err
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   localparam logic [1:0]                 LANE_LAST = 2'(NUM_BANKS - 1);
   localparam logic [BANK_ADDR_WIDTH-1:0] ROW_LAST  = BANK_ADDR_WIDTH'(ROWS_PER_BANK - 1);

   // Reset asserts immediately, releases two clocks after i_rst falls.
   logic [1:0] rst_q;
   logic       rst;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) rst_q <= 2'b11;
      else       rst_q <= {rst_q[0], 1'b0};
   end
   assign rst = rst_q[1];

   state_t                             state_q, state_d;
   logic [1:0]                         lane_q, lane_d;
   logic [BANK_ADDR_WIDTH-1:0]         row_q, row_d;
   logic [2:0][ROI_BITS-1:0]           stage_q, stage_d;
   logic                               wr_en_q, wr_en_d;
   logic [BANK_ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
   logic [3:0][ROI_BITS-1:0]           wr_data_q, wr_data_d;
   logic                               err_q, err_d;
   logic [QUBIT_ID_WIDTH-1:0]          exp_q, exp_d;
   logic                               acc;

   // A start strobe always outranks a transfer in the same cycle.
   assign acc = (state_q == FILL) && i_px_valid && !i_start;

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      row_d     = row_q;
      stage_d   = stage_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      exp_d     = exp_q;

      case (state_q)
         IDLE:    if (i_start) state_d = FILL;
         FILL:    state_d = FILL;
         DONE:    state_d = i_start ? FILL : IDLE;
         default: state_d = IDLE;
      endcase

      if (i_start) begin
         lane_d  = '0;
         row_d   = '0;
         stage_d = '0;
         err_d   = 1'b0;
         exp_d   = '0;
      end else if (acc) begin
         exp_d = exp_q + 1'b1;
`ifdef WRITE_STREAM_ID_CHECK_EN
         if (i_px_qubit_id != exp_q) err_d = 1'b1;
`endif
         case (lane_q)
            2'd0:    stage_d[0] = i_px_data;
            2'd1:    stage_d[1] = i_px_data;
            2'd2:    stage_d[2] = i_px_data;
            default: stage_d    = stage_q;
         endcase
         if (lane_q == LANE_LAST) begin
            lane_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = row_q;
            wr_data_d = {i_px_data, stage_q[2], stage_q[1], stage_q[0]};
            if (row_q == ROW_LAST) begin
               row_d   = '0;
               state_d = DONE;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lane_q    <= '0;
         row_q     <= '0;
         stage_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
         exp_q     <= '0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         row_q     <= row_d;
         stage_q   <= stage_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
         exp_q     <= exp_d;
      end
   end

`ifdef WRITE_STREAM_ID_CHECK_EN
   assign o_id_err = err_q;
`else
   logic unused_id;
   assign unused_id = ^{i_px_qubit_id, err_q, exp_q};
   assign o_id_err  = 1'b0;
`endif

   assign o_px_ready   = (state_q == FILL);
   assign o_busy       = (state_q != IDLE);
   assign o_frame_done = (state_q == DONE);
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data_0  = wr_data_q[0];
   assign o_wr_data_1  = wr_data_q[1];
   assign o_wr_data_2  = wr_data_q[2];
   assign o_wr_data_3  = wr_data_q[3];

endmodule

// File: tb/tb_bank_write_streamer.sv
// Scoreboard bench: stimulus pushes expected row writes, a negedge monitor pops and compares.
module tb_bank_write_streamer;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_px_valid = 1'b0;
   logic [15:0] i_px_data = '0;
   logic [6:0]  i_px_qubit_id = '0;
   logic        o_px_ready, o_wr_en, o_busy, o_frame_done, o_id_err;
   logic [4:0]  o_wr_addr;
   logic [15:0] o_wr_data_0, o_wr_data_1, o_wr_data_2, o_wr_data_3;

   bank_write_streamer dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
      .i_px_valid(i_px_valid), .i_px_data(i_px_data), .i_px_qubit_id(i_px_qubit_id),
      .o_px_ready(o_px_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data_0(o_wr_data_0), .o_wr_data_1(o_wr_data_1),
      .o_wr_data_2(o_wr_data_2), .o_wr_data_3(o_wr_data_3),
      .o_busy(o_busy), .o_frame_done(o_frame_done), .o_id_err(o_id_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [4:0]       addr;
      logic [3:0][15:0] d;
      logic             done;
   } wr_t;

   wr_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          k = 0;
   logic [15:0] lanes [4];
`ifdef WRITE_STREAM_ID_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every write must match the oldest queued expectation.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_wr_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write_addr", {27'd0, o_wr_addr}, 32'hffff_ffff);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", {27'd0, o_wr_addr}, {27'd0, e.addr});
               chk("wr_data_0", {16'd0, o_wr_data_0}, {16'd0, e.d[0]});
               chk("wr_data_1", {16'd0, o_wr_data_1}, {16'd0, e.d[1]});
               chk("wr_data_2", {16'd0, o_wr_data_2}, {16'd0, e.d[2]});
               chk("wr_data_3", {16'd0, o_wr_data_3}, {16'd0, e.d[3]});
               chk("frame_done", {31'd0, o_frame_done}, {31'd0, e.done});
            end
         end else if (o_frame_done) begin
            chk("frame_done_without_write", 32'd1, 32'd0);
         end
      end
   end

   // All tasks begin and end 1 time unit after a rising edge.
   task automatic start_pulse();
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      k = 0;
   endtask

   task automatic xfer(input logic [15:0] d, input logic [6:0] id);
      wr_t e;
      i_px_valid = 1'b1; i_px_data = d; i_px_qubit_id = id;
      lanes[k % 4] = d;
      if (k % 4 == 3) begin
         e.addr = 5'(k / 4);
         e.d    = {lanes[3], lanes[2], lanes[1], lanes[0]};
         e.done = (k / 4 == 24);
         exp_q.push_back(e);
      end
      @(posedge i_clk); #1;
      i_px_valid = 1'b0;
      k++;
   endtask

   task automatic gap(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({tag, "_wr_en"}, {31'd0, o_wr_en}, 32'd0);
      chk({tag, "_wr_addr"}, {27'd0, o_wr_addr}, 32'd0);
      chk({tag, "_wr_data"}, {o_wr_data_1, o_wr_data_0}, 32'd0);
      chk({tag, "_wr_data_hi"}, {o_wr_data_3, o_wr_data_2}, 32'd0);
      chk({tag, "_ready"}, {31'd0, o_px_ready}, 32'd0);
      chk({tag, "_frame_done"}, {31'd0, o_frame_done}, 32'd0);
      chk({tag, "_id_err"}, {31'd0, o_id_err}, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1 chk_zero("reset");
      i_rst = 1'b0;
      gap(4);

      // Valid in IDLE is ignored
      i_px_valid = 1'b1; i_px_data = 16'hdead;
      for (int i = 0; i < 5; i++) begin
         gap(1);
         chk("idle_ready", {31'd0, o_px_ready}, 32'd0);
      end
      i_px_valid = 1'b0;

      // Frame 1: back-to-back, data = k
      start_pulse();
      chk("fill_busy", {31'd0, o_busy}, 32'd1);
      chk("fill_ready", {31'd0, o_px_ready}, 32'd1);
      for (int i = 0; i < 100; i++) xfer(16'(i), 7'(i));
      chk("done_busy", {31'd0, o_busy}, 32'd1);
      chk("done_pulse", {31'd0, o_frame_done}, 32'd1);
      chk("done_ready", {31'd0, o_px_ready}, 32'd0);
      gap(1);
      chk("after_done_busy", {31'd0, o_busy}, 32'd0);
      chk("after_done_pulse", {31'd0, o_frame_done}, 32'd0);
      chk("frame1_id_err", {31'd0, o_id_err}, 32'd0);

      // Frame 2: random gaps between transfers
      start_pulse();
      for (int i = 0; i < 100; i++) begin
         gap(int'($urandom_range(0, 2)));
         xfer(16'(1000 + i), 7'(i));
      end
      // Start during DONE restarts immediately
      start_pulse();
      chk("start_in_done_busy", {31'd0, o_busy}, 32'd1);
      chk("start_in_done_ready", {31'd0, o_px_ready}, 32'd1);

      // Frame 3: 10 transfers, start colliding with a transfer, then a full frame
      for (int i = 0; i < 10; i++) xfer(16'(5000 + i), 7'(i));
      i_start = 1'b1; i_px_valid = 1'b1; i_px_data = 16'h9999;
      @(posedge i_clk); #1;
      i_start = 1'b0; i_px_valid = 1'b0; k = 0;
      for (int i = 0; i < 100; i++) xfer(16'(2000 + i), 7'(i));
      gap(2);
      chk("frame3_idle", {31'd0, o_busy}, 32'd0);

      // Frame 4: reset mid-frame after 50 transfers
      start_pulse();
      for (int i = 0; i < 50; i++) xfer(16'(3000 + i), 7'(i));
      #2 i_rst = 1'b1;
      #1 chk_zero("midreset");
      @(posedge i_clk); #1 i_rst = 1'b0;
      i_px_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         gap(1);
         chk("post_reset_ready", {31'd0, o_px_ready}, 32'd0);
         chk("post_reset_busy", {31'd0, o_busy}, 32'd0);
      end
      i_px_valid = 1'b0;

      // Frame 5: wrong qubit ID at k=6
      start_pulse();
      for (int i = 0; i < 100; i++) begin
         xfer(16'(4000 + i), (i == 6) ? 7'd7 : 7'(i));
         if (i == 5) chk("id_err_before", {31'd0, o_id_err}, 32'd0);
         if (i == 6) chk("id_err_at_6", {31'd0, o_id_err}, {31'd0, ERR_EXP});
      end
      chk("id_err_sticky", {31'd0, o_id_err}, {31'd0, ERR_EXP});
      gap(2);
      chk("id_err_idle", {31'd0, o_id_err}, {31'd0, ERR_EXP});
      start_pulse();
      chk("id_err_cleared", {31'd0, o_id_err}, 32'd0);
      gap(2);

      chk("pending_writes", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bank_write_streamer.md
BANK_WRITE_STREAMER -- requirements
Module: bank_write_streamer

Interface
REQ-001 SHALL have parameter ROI_BITS, default 16, width of one qubit ROI pixel sum.
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of parallel memory banks; only 4 is supported.
REQ-003 SHALL have parameter ROWS_PER_BANK, default 25, rows per frame; a frame holds NUM_BANKS*ROWS_PER_BANK qubits.
REQ-004 SHALL have parameter BANK_ADDR_WIDTH, default 5, row-address width.
REQ-005 SHALL have parameter QUBIT_ID_WIDTH, default 7, qubit-index width.
REQ-006 SHALL have port i_clk, input, 1, sole clock; all logic is on the rising edge.
REQ-007 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_start, input, 1, single-cycle frame-start strobe.
REQ-009 SHALL have port i_px_valid, input, 1, pixel sum present.
REQ-010 SHALL have port i_px_data, input, ROI_BITS, ROI pixel sum.
REQ-011 SHALL have port i_px_qubit_id, input, QUBIT_ID_WIDTH, index of the qubit carried in i_px_data.
REQ-012 SHALL have port o_px_ready, output, 1, pixel accepted when high together with i_px_valid.
REQ-013 SHALL have port o_wr_en, output, 1, bank write strobe common to all banks.
REQ-014 SHALL have port o_wr_addr, output, BANK_ADDR_WIDTH, row index 0..ROWS_PER_BANK-1.
REQ-015 SHALL have ports o_wr_data_0..o_wr_data_3, output, ROI_BITS each, write data for banks 0..3.
REQ-016 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.
REQ-017 SHALL have port o_frame_done, output, 1, one-cycle pulse when the frame is fully written.
REQ-018 SHALL have port o_id_err, output, 1, sticky qubit-ID mismatch flag.

Function
REQ-019 SHALL implement states IDLE, FILL and DONE; o_px_ready SHALL be 1 only in FILL.
REQ-020 In IDLE, i_start SHALL clear the lane counter, row counter, expected-ID counter and o_id_err, and SHALL enter FILL.
REQ-021 A transfer SHALL occur when i_px_valid and o_px_ready are both 1; idle cycles between transfers are allowed with no limit.
REQ-022 The k-th transfer of a frame (k from 0) SHALL go to bank k mod 4 and row k div 4.
REQ-023 Transfers to lanes 0..2 SHALL be staged in internal registers and SHALL NOT drive outputs.
REQ-024 On the edge that accepts lane 3, o_wr_en SHALL register 1, o_wr_addr the row count, o_wr_data_0..2 the staged values and o_wr_data_3 i_px_data; the write is visible the following cycle.
REQ-025 o_wr_en SHALL last exactly one cycle per row; o_wr_data and o_wr_addr SHALL hold their values until the next write.
REQ-026 FILL SHALL accept a new lane-0 transfer in the same cycle that a row write is presented; there is no write bubble.
REQ-027 The row counter SHALL increment after each lane-3 accept and SHALL NOT exceed ROWS_PER_BANK-1.
REQ-028 When the row ROWS_PER_BANK-1 lane-3 transfer is accepted, the state SHALL go to DONE at that edge.
REQ-029 DONE SHALL last one cycle, assert o_frame_done (aligned with the final o_wr_en) and then go to IDLE.
REQ-030 i_start in FILL SHALL restart the frame: staged data discarded, counters cleared, state remains FILL, no o_wr_en.
REQ-031 When i_start and a transfer occur in the same FILL cycle, i_start SHALL win and the transfer SHALL be dropped.
REQ-032 i_start in DONE SHALL be honoured: o_frame_done still pulses that cycle and the next state is FILL.
REQ-033 i_px_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-034 i_rst SHALL asynchronously force IDLE, clear all counters and staged lanes, and set every output to 0, including o_wr_data_0..3 and o_wr_addr.
REQ-035 Reset mid-frame SHALL abandon the frame with no further write or o_frame_done; deassertion SHALL be synchronised to i_clk.

Configuration
REQ-036 With WRITE_STREAM_ID_CHECK_EN defined, each transfer SHALL compare i_px_qubit_id with the expected index k; on mismatch o_id_err SHALL set and stay set until i_start or reset, and the data is still written at position k.
REQ-037 Without WRITE_STREAM_ID_CHECK_EN, i_px_qubit_id SHALL be ignored and o_id_err SHALL be tied to 0.

Verification
REQ-038 i_start, then 100 back-to-back transfers with data=k -> 25 o_wr_en pulses, address r with data {4r, 4r+1, 4r+2, 4r+3}; o_frame_done coincides with the address-24 write; o_busy drops the next cycle.
REQ-039 Same frame with random valid gaps -> identical write sequence; writes occur only after every 4th accept.
REQ-040 i_start after 10 transfers, then 100 transfers -> first write is address 0 with data from the new frame; exactly 25 writes.
REQ-041 i_rst asserted mid-cycle after 50 transfers -> outputs 0 immediately; no further writes; i_px_valid ignored after release until i_start.
REQ-042 With the macro defined, qubit ID 7 sent at k=6 -> o_id_err rises at k=6 and stays high; all 25 writes still occur; with the macro undefined o_id_err stays 0.
REQ-043 i_px_valid held high in IDLE -> o_px_ready stays 0 and no write occurs.
